fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, sets the instruction buffer entry count; power of two, minimum 2.
REQ-002 Parameter MAX_OUT, default 2, sets the maximum number of outstanding imem requests; minimum 1.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-low.
REQ-005 PC_IF  input  32  current fetch PC from the PC register.
REQ-006 PC_EN  output  1  advance enable to the PC register.
REQ-007 IMEM_REQ  output  1  instruction memory read request.
REQ-008 IMEM_ADDR  output  32  request word address.
REQ-009 IMEM_GNT  input  1  memory accepts the request this cycle.
REQ-010 IMEM_RVALID  input  1  read response valid; responses return in order, at least 1 cycle after grant.
REQ-011 IMEM_RDATA  input  32  response instruction word.
REQ-012 FLUSH  input  1  redirect; discard buffered and in-flight fetches.
REQ-013 ID_VALID  output  1  instruction available to decode.
REQ-014 ID_READY  input  1  decode accepts the instruction.
REQ-015 ID_INSTR  output  32  instruction at buffer head.
REQ-016 ID_PC  output  32  PC of ID_INSTR.
REQ-017 ID_PC4  output  32  ID_PC+4, modulo 2^32.
REQ-018 ERR  output  1  sticky protocol-error flag.

Function
REQ-019 IMEM_ADDR SHALL equal {PC_IF[31:2],2'b00}, combinationally.
REQ-020 IMEM_REQ SHALL be 1 iff FLUSH=0, outstanding<MAX_OUT, and (occupancy+outstanding)<DEPTH, all evaluated from registered counts only; no combinational path from ID_READY or IMEM_RVALID to IMEM_REQ.
REQ-021 PC_EN SHALL equal IMEM_REQ & IMEM_GNT; the request is issued in that cycle.
REQ-022 On issue, IMEM_ADDR SHALL be pushed into a MAX_OUT-entry in-order PC tag queue, and outstanding SHALL increment.
REQ-023 On IMEM_RVALID with outstanding>0, outstanding SHALL decrement and the tag queue SHALL pop; if drop count=0, {tag, IMEM_RDATA} SHALL be written to the buffer tail.
REQ-024 A same-cycle issue and response SHALL leave outstanding unchanged.
REQ-025 ID_VALID SHALL be 1 iff occupancy>0; ID_INSTR/ID_PC/ID_PC4 SHALL come from the buffer head and stay stable while ID_VALID=1 and ID_READY=0.
REQ-026 A transfer occurs when ID_VALID & ID_READY; the head SHALL then pop.
REQ-027 A same-cycle buffer write and pop SHALL leave occupancy unchanged, including when the buffer is full.
REQ-028 Buffer pointers SHALL wrap modulo DEPTH; occupancy is never allowed to exceed DEPTH, which REQ-020 guarantees.
REQ-029 FLUSH=1 SHALL empty the buffer and set drop count to outstanding after this cycle's update, including any grant or response in the same cycle.
REQ-030 A response arriving while drop count>0 SHALL be discarded and SHALL decrement drop count; this includes a response in the FLUSH cycle itself.
REQ-031 While FLUSH=1, ID_VALID SHALL still reflect pre-flush occupancy, but any transfer that cycle is void from the fetch side.
REQ-032 IMEM_REQ SHALL remain low in any cycle in which drop count>0 and (drop count+occupancy+outstanding)>=DEPTH; issue resumes otherwise.
REQ-033 IMEM_RVALID while outstanding=0 SHALL be ignored and SHALL set ERR; ERR clears only on reset.

Reset
REQ-034 While RST=0: occupancy, outstanding, drop count, and pointers SHALL be 0, and ERR=0.
REQ-035 While RST=0: ID_VALID=0, IMEM_REQ=0, PC_EN=0.
REQ-036 The first request SHALL be possible in the first rising edge after RST deasserts.
REQ-037 Reset mid-operation SHALL abandon all in-flight state; responses after release with outstanding=0 follow REQ-033.

Verification
REQ-038 Streaming: PC_IF=0x0,0x4,0x8; GNT=1; 1-cycle latency; ID_READY=1 -> ID_PC 0x0,0x4,0x8 on consecutive cycles, ID_PC4 0x4,0x8,0xC, and instructions match.
REQ-039 Backpressure: ID_READY=0, DEPTH=2 -> exactly 2 issues, then IMEM_REQ=0; ID outputs held stable; ID_READY=1 -> one issue per pop.
REQ-040 Flush with 2 outstanding: FLUSH pulse, then 2 responses 0xDEAD0001/0xDEAD0002 -> neither appears on ID; the next fetch (PC_IF=0x100) appears with ID_PC=0x100.
REQ-041 FLUSH in the same cycle as a grant and a response -> both fetches dropped; drop count=1 afterward.
REQ-042 Spurious IMEM_RVALID after reset -> ERR=1, ID_VALID stays 0, and ERR remains set until RST=0.
REQ-043 Wrap: PC_IF=0xFFFFFFFC -> ID_PC4=0x00000000; 10 fetches through DEPTH=2 -> in-order delivery across pointer wrap.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Issues in-order imem reads for the
// current PC, tags each request with its PC, collects responses into a small
// instruction buffer, and hands instructions to decode with valid/ready.
// A flush empties the buffer and marks in-flight fetches to be dropped.
module fetch_unit #(
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_IF,
    output logic        PC_EN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        FLUSH,
    output logic        ID_VALID,
    input  logic        ID_READY,
    output logic [31:0] ID_INSTR,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC4,
    output logic        ERR
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    // Counter width covers drop+occupancy+outstanding without overflow.
    localparam int CW = $clog2(DEPTH + 2 * MAX_OUT + 1) + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUT);
    localparam logic [TW-1:0] TQ_LAST = TW'(MAX_OUT - 1);

    logic [CW-1:0] occ, outst, drop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] tq_wr, tq_rd;
    logic          err_q;

    logic [31:0] tag_q      [MAX_OUT];
    logic [31:0] ibuf_instr [DEPTH];
    logic [31:0] ibuf_pc    [DEPTH];

    logic          issue, rsp, rsp_keep, pop;
    logic [CW-1:0] outst_nxt;

    // Request gating uses registered counts only, so decode backpressure and
    // memory responses never reach IMEM_REQ combinationally. While draining
    // dropped fetches, new issue waits until the dropped ones are accounted for.
    always_comb begin
        IMEM_ADDR = {PC_IF[31:2], 2'b00};
        IMEM_REQ  = RST && !FLUSH
                    && (outst < MAX_C)
                    && ((occ + outst) < DEPTH_C)
                    && !((drop != '0) && ((drop + occ + outst) >= DEPTH_C));
        PC_EN     = IMEM_REQ & IMEM_GNT;
        issue     = PC_EN;
        rsp       = IMEM_RVALID && (outst != '0);
        rsp_keep  = rsp && (drop == '0) && !FLUSH;
        pop       = ID_VALID && ID_READY && !FLUSH;
        outst_nxt = outst + CW'(issue) - CW'(rsp);
    end

    // Decode-side view of the buffer head.
    always_comb begin
        ID_VALID = (occ != '0);
        ID_INSTR = ibuf_instr[rd_ptr];
        ID_PC    = ibuf_pc[rd_ptr];
        ID_PC4   = ibuf_pc[rd_ptr] + 32'd4;
        ERR      = err_q;
    end

    // Control state: counters, pointers, drop accounting and sticky error.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            occ    <= '0;
            outst  <= '0;
            drop   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            tq_wr  <= '0;
            tq_rd  <= '0;
            err_q  <= 1'b0;
        end else begin
            outst <= outst_nxt;
            if (issue)
                tq_wr <= (tq_wr == TQ_LAST) ? '0 : tq_wr + TW'(1);
            if (rsp)
                tq_rd <= (tq_rd == TQ_LAST) ? '0 : tq_rd + TW'(1);
            if (IMEM_RVALID && (outst == '0))
                err_q <= 1'b1;
            if (FLUSH) begin
                // Everything still in flight after this cycle must be dropped.
                occ    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                drop   <= outst_nxt;
            end else begin
                if (rsp && (drop != '0))
                    drop <= drop - CW'(1);
                if (rsp_keep)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                occ <= occ + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

    // Datapath storage: PC tags of in-flight requests and buffered instructions.
    always_ff @(posedge CLK) begin
        if (issue)
            tag_q[tq_wr] <= IMEM_ADDR;
        if (rsp_keep) begin
            ibuf_instr[wr_ptr] <= IMEM_RDATA;
            ibuf_pc[wr_ptr]    <= tag_q[tq_rd];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit. A DEPTH=2 instance is the main
// target; a DEPTH=4 instance sharing the same inputs is used for streaming.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        gnt, rvalid, flush, id_ready;
    logic [31:0] rdata;

    logic        pc_en, imem_req, id_valid, err;
    logic [31:0] imem_addr, id_instr, id_pc, id_pc4;
    logic        pc_en_4, imem_req_4, id_valid_4, err_4;
    logic [31:0] imem_addr_4, id_instr_4, id_pc_4, id_pc4_4;

    int runs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(2), .MAX_OUT(2)) dut (
        .CLK(clk), .RST(rst_n), .PC_IF(pc_if), .PC_EN(pc_en),
        .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_GNT(gnt),
        .IMEM_RVALID(rvalid), .IMEM_RDATA(rdata), .FLUSH(flush),
        .ID_VALID(id_valid), .ID_READY(id_ready), .ID_INSTR(id_instr),
        .ID_PC(id_pc), .ID_PC4(id_pc4), .ERR(err)
    );

    fetch_unit #(.DEPTH(4), .MAX_OUT(2)) dut4 (
        .CLK(clk), .RST(rst_n), .PC_IF(pc_if), .PC_EN(pc_en_4),
        .IMEM_REQ(imem_req_4), .IMEM_ADDR(imem_addr_4), .IMEM_GNT(gnt),
        .IMEM_RVALID(rvalid), .IMEM_RDATA(rdata), .FLUSH(flush),
        .ID_VALID(id_valid_4), .ID_READY(id_ready), .ID_INSTR(id_instr_4),
        .ID_PC(id_pc_4), .ID_PC4(id_pc4_4), .ERR(err_4)
    );

    // Inputs change 1 time unit after a rising edge; checks follow #1 later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        pc_if = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        flush = 1'b0; id_ready = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        idle();
        rst_n = 1'b0; gnt = 1'b1; pc_if = 32'h0000_1237; id_ready = 1'b1;
        tick();
        runs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %0b exp 0", imem_req); end
        runs++; if (pc_en !== 1'b0) begin fails++; $display("FAIL rst_pc_en got %0b exp 0", pc_en); end
        runs++; if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid got %0b exp 0", id_valid); end
        runs++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %0b exp 0", err); end
        runs++; if (imem_addr !== 32'h0000_1234) begin fails++; $display("FAIL rst_addr got %h exp 00001234", imem_addr); end
        rvalid = 1'b1;
        tick();
        runs++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err_hold got %0b exp 0", err); end
        rvalid = 1'b0; gnt = 1'b0; rst_n = 1'b1;
        #1;
        runs++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rst_first_req got %0b exp 1", imem_req); end
        tick();
    endtask

    task automatic test_stream;
        do_reset();
        pc_if = 32'h0; gnt = 1'b1; id_ready = 1'b1;
        #1;
        runs++; if (pc_en_4 !== 1'b1) begin fails++; $display("FAIL stream_issue0 got %0b exp 1", pc_en_4); end
        tick();
        pc_if = 32'h4; rvalid = 1'b1; rdata = 32'h0000_0013;
        tick();
        pc_if = 32'h8; rdata = 32'h0010_0093;
        #1;
        runs++; if (id_valid_4 !== 1'b1 || id_pc_4 !== 32'h0 || id_pc4_4 !== 32'h4 || id_instr_4 !== 32'h0000_0013) begin
            fails++; $display("FAIL stream_0 got v=%0b pc=%h pc4=%h i=%h exp v=1 pc=0 pc4=4 i=00000013", id_valid_4, id_pc_4, id_pc4_4, id_instr_4); end
        tick();
        pc_if = 32'hC; rdata = 32'h0020_0113;
        #1;
        runs++; if (id_valid_4 !== 1'b1 || id_pc_4 !== 32'h4 || id_pc4_4 !== 32'h8 || id_instr_4 !== 32'h0010_0093) begin
            fails++; $display("FAIL stream_1 got v=%0b pc=%h pc4=%h i=%h exp v=1 pc=4 pc4=8 i=00100093", id_valid_4, id_pc_4, id_pc4_4, id_instr_4); end
        tick();
        gnt = 1'b0; rdata = 32'h1234_5678;
        #1;
        runs++; if (id_valid_4 !== 1'b1 || id_pc_4 !== 32'h8 || id_pc4_4 !== 32'hC || id_instr_4 !== 32'h0020_0113) begin
            fails++; $display("FAIL stream_2 got v=%0b pc=%h pc4=%h i=%h exp v=1 pc=8 pc4=c i=00200113", id_valid_4, id_pc_4, id_pc4_4, id_instr_4); end
        tick();
        idle();
    endtask

    task automatic test_backpressure;
        do_reset();
        pc_if = 32'h40; gnt = 1'b1; id_ready = 1'b0;
        tick();
        pc_if = 32'h44; rvalid = 1'b1; rdata = 32'hA000_0040;
        #1;
        runs++; if (pc_en !== 1'b1) begin fails++; $display("FAIL bp_issue2 got %0b exp 1", pc_en); end
        tick();
        pc_if = 32'h48; rdata = 32'hA000_0044;
        #1;
        runs++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin fails++; $display("FAIL bp_stop1 got req=%0b en=%0b exp 0 0", imem_req, pc_en); end
        tick();
        rvalid = 1'b0;
        #1;
        runs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_stop2 got %0b exp 0", imem_req); end
        runs++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'hA000_0040) begin
            fails++; $display("FAIL bp_head got v=%0b pc=%h i=%h exp v=1 pc=40 i=a0000040", id_valid, id_pc, id_instr); end
        tick();
        #1;
        runs++; if (id_pc !== 32'h40 || id_instr !== 32'hA000_0040 || id_pc4 !== 32'h44) begin
            fails++; $display("FAIL bp_stable got pc=%h i=%h pc4=%h exp 40 a0000040 44", id_pc, id_instr, id_pc4); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        runs++; if (pc_en !== 1'b1 || id_pc !== 32'h44) begin fails++; $display("FAIL bp_resume got en=%0b pc=%h exp 1 44", pc_en, id_pc); end
        tick();
        #1;
        runs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_one_per_pop got %0b exp 0", imem_req); end
        idle();
        tick();
    endtask

    task automatic test_flush_outstanding;
        do_reset();
        pc_if = 32'h80; gnt = 1'b1; id_ready = 1'b1;
        tick();
        pc_if = 32'h84;
        tick();
        gnt = 1'b0; flush = 1'b1;
        #1;
        runs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fl_req_in_flush got %0b exp 0", imem_req); end
        tick();
        flush = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_0001;
        #1;
        runs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fl_req_drain got %0b exp 0", imem_req); end
        tick();
        rdata = 32'hDEAD_0002;
        #1;
        runs++; if (id_valid !== 1'b0) begin fails++; $display("FAIL fl_drop1 got %0b exp 0", id_valid); end
        tick();
        rvalid = 1'b0; pc_if = 32'h100; gnt = 1'b1;
        #1;
        runs++; if (id_valid !== 1'b0) begin fails++; $display("FAIL fl_drop2 got %0b exp 0", id_valid); end
        runs++; if (imem_req !== 1'b1) begin fails++; $display("FAIL fl_resume got %0b exp 1", imem_req); end
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_0100;
        tick();
        rvalid = 1'b0;
        #1;
        runs++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'hCAFE_0100) begin
            fails++; $display("FAIL fl_next got v=%0b pc=%h i=%h exp 1 100 cafe0100", id_valid, id_pc, id_instr); end
        tick();
        idle();
    endtask

    task automatic test_flush_grant_rsp;
        do_reset();
        pc_if = 32'h200; gnt = 1'b1; id_ready = 1'b0;
        tick();
        pc_if = 32'h204;
        tick();
        flush = 1'b1; rvalid = 1'b1; rdata = 32'hBAD0_0200;
        #1;
        runs++; if (pc_en !== 1'b0) begin fails++; $display("FAIL fgr_no_issue got %0b exp 0", pc_en); end
        tick();
        flush = 1'b0; rvalid = 1'b0; pc_if = 32'h300;
        #1;
        runs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fgr_drop_pending got %0b exp 0", imem_req); end
        tick();
        rvalid = 1'b1; rdata = 32'hBAD0_0204;
        tick();
        rvalid = 1'b0;
        #1;
        runs++; if (id_valid !== 1'b0) begin fails++; $display("FAIL fgr_dropped got %0b exp 0", id_valid); end
        runs++; if (pc_en !== 1'b1) begin fails++; $display("FAIL fgr_resume got %0b exp 1", pc_en); end
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0300_C0DE;
        tick();
        rvalid = 1'b0;
        #1;
        runs++; if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_instr !== 32'h0300_C0DE) begin
            fails++; $display("FAIL fgr_next got v=%0b pc=%h i=%h exp 1 300 0300c0de", id_valid, id_pc, id_instr); end
        flush = 1'b1; id_ready = 1'b1;
        #1;
        runs++; if (id_valid !== 1'b1) begin fails++; $display("FAIL fgr_valid_in_flush got %0b exp 1", id_valid); end
        tick();
        flush = 1'b0; id_ready = 1'b0;
        #1;
        runs++; if (id_valid !== 1'b0) begin fails++; $display("FAIL fgr_flushed got %0b exp 0", id_valid); end
        idle();
        tick();
    endtask

    task automatic test_spurious;
        do_reset();
        rvalid = 1'b1; rdata = 32'h1111_1111;
        tick();
        rvalid = 1'b0;
        #1;
        runs++; if (err !== 1'b1) begin fails++; $display("FAIL spur_err got %0b exp 1", err); end
        runs++; if (id_valid !== 1'b0) begin fails++; $display("FAIL spur_valid got %0b exp 0", id_valid); end
        tick();
        tick();
        runs++; if (err !== 1'b1) begin fails++; $display("FAIL spur_sticky got %0b exp 1", err); end
        rst_n = 1'b0;
        #1;
        runs++; if (err !== 1'b0) begin fails++; $display("FAIL spur_clear got %0b exp 0", err); end
        tick();
    endtask

    task automatic test_reset_midop;
        do_reset();
        pc_if = 32'h500; gnt = 1'b1;
        tick();
        gnt = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h0500_0500;
        tick();
        rvalid = 1'b0;
        #1;
        runs++; if (err !== 1'b1 || id_valid !== 1'b0) begin
            fails++; $display("FAIL midrst got err=%0b v=%0b exp 1 0", err, id_valid); end
        tick();
    endtask

    task automatic test_wrap;
        logic [31:0] pc;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            pc = 32'hFFFF_FFFC + 32'(k * 4);
            pc_if = pc; gnt = 1'b1; id_ready = 1'b1; rvalid = 1'b0;
            #1;
            runs++; if (pc_en !== 1'b1) begin fails++; $display("FAIL wrap_issue k=%0d got %0b exp 1", k, pc_en); end
            tick();
            gnt = 1'b0; rvalid = 1'b1; rdata = pc ^ 32'h5A5A_5A5A;
            tick();
            rvalid = 1'b0;
            #1;
            runs++; if (id_valid !== 1'b1 || id_pc !== pc || id_pc4 !== pc + 32'd4 || id_instr !== (pc ^ 32'h5A5A_5A5A)) begin
                fails++; $display("FAIL wrap_deliver k=%0d got v=%0b pc=%h pc4=%h i=%h exp pc=%h", k, id_valid, id_pc, id_pc4, id_instr, pc); end
            if (k == 0) begin
                runs++; if (id_pc4 !== 32'h0) begin fails++; $display("FAIL wrap_pc4 got %h exp 00000000", id_pc4); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_outstanding();
        test_flush_grant_rsp();
        test_spurious();
        test_reset_midop();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule
